ascon_ecg_feeder: RTL and testbench

Upstream sequencer for the ascon core. It collects a fixed-length ECG sample record as a byte stream and packs the bytes MSB-first into 64-bit blocks. It drives the ascon handshake: init, one associated-data block, full plaintext blocks, then the padded final block with finalisation. It returns each cipher word and the 128-bit tag to the downstream transmit logic.

---
 rtl/ascon_ecg_feeder.sv | 155 +++++++++++++++
 tb/tb_ascon_ecg_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ecg_feeder.sv
`default_nettype none
// ascon_ecg_feeder : packs an ECG byte record MSB-first into 64-bit blocks and
// sequences the ascon init / AD / plaintext / finalisation handshake.  rev 1.0
module ascon_ecg_feeder #(
  parameter int          NB_BYTES = 181,
  parameter logic [63:0] AD_WORD  = 64'h4120746F20428000
) (
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          start_i,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  output logic          init_o,
  output logic          associate_data_o,
  output logic          finalisation_o,
  output logic [63:0]   data_o,
  output logic          data_valid_o,
  input  logic          end_initialisation_i,
  input  logic          end_associate_i,
  input  logic [63:0]   cipher_i,
  input  logic          cipher_valid_i,
  input  logic          end_cipher_i,
  input  logic [127:0]  tag_i,
  input  logic          end_tag_i,
  output logic [63:0]   cipher_word_o,
  output logic          cipher_word_valid_o,
  output logic [7:0]    cipher_index_o,
  output logic [127:0]  tag_o,
  output logic          tag_valid_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [7:0] NFULL    = 8'(NB_BYTES / 8);
  localparam logic [2:0] REM      = 3'(NB_BYTES % 8);
  localparam logic [2:0] REM_LAST = (NB_BYTES % 8 == 0) ? 3'd0 : 3'(NB_BYTES % 8 - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    WAIT_INIT  = 4'd2,
    AD         = 4'd3,
    WAIT_AD    = 4'd4,
    FILL       = 4'd5,
    PT         = 4'd6,
    WAIT_CV    = 4'd7,
    WAIT_EC    = 4'd8,
    FINAL_FILL = 4'd9,
    FINAL      = 4'd10,
    WAIT_CVF   = 4'd11,
    WAIT_TAG   = 4'd12,
    DONE       = 4'd13
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [63:0] block;
  logic [63:0] block_nxt;
  logic [2:0]  byte_cnt;
  logic [7:0]  blk_cnt;
  logic        take;

  assign take = byte_valid_i & byte_ready_o;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start_i) nxt = INIT;
      INIT:       nxt = WAIT_INIT;
      WAIT_INIT:  if (end_initialisation_i) nxt = AD;
      AD:         nxt = WAIT_AD;
      WAIT_AD:    if (end_associate_i) nxt = (NFULL == 8'd0) ? FINAL_FILL : FILL;
      FILL:       if (take && byte_cnt == 3'd7) nxt = PT;
      PT:         nxt = WAIT_CV;
      WAIT_CV:    if (cipher_valid_i) nxt = WAIT_EC;
      WAIT_EC:    if (end_cipher_i) nxt = (blk_cnt + 8'd1 == NFULL) ? FINAL_FILL : FILL;
      FINAL_FILL: if (REM == 3'd0 || (take && byte_cnt == REM_LAST)) nxt = FINAL;
      FINAL:      nxt = WAIT_CVF;
      WAIT_CVF:   if (cipher_valid_i) nxt = WAIT_TAG;
      WAIT_TAG:   if (end_tag_i) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  // Entering FINAL_FILL pre-loads the 0x80 pad just after the R data bytes.
  always_comb begin
    block_nxt = block;
    if (nxt == FINAL_FILL && state != FINAL_FILL)
      block_nxt = 64'h80 << {~REM, 3'b000};
    else if (take)
      block_nxt[{~byte_cnt, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state               <= IDLE;
      block               <= '0;
      byte_cnt            <= '0;
      blk_cnt             <= '0;
      byte_ready_o        <= 1'b0;
      init_o              <= 1'b0;
      associate_data_o    <= 1'b0;
      finalisation_o      <= 1'b0;
      data_o              <= '0;
      data_valid_o        <= 1'b0;
      cipher_word_o       <= '0;
      cipher_word_valid_o <= 1'b0;
      cipher_index_o      <= '0;
      tag_o               <= '0;
      tag_valid_o         <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      state <= nxt;
      block <= block_nxt;
      if (nxt == INIT) begin
        byte_cnt <= '0;
        blk_cnt  <= '0;
      end else begin
        if (take) byte_cnt <= byte_cnt + 3'd1;
        if (state == WAIT_EC && end_cipher_i) blk_cnt <= blk_cnt + 8'd1;
      end

      byte_ready_o     <= (nxt == FILL) || (nxt == FINAL_FILL && REM != 3'd0);
      init_o           <= (nxt == INIT) || (nxt == WAIT_INIT);
      associate_data_o <= (nxt == AD) || (nxt == WAIT_AD);
      finalisation_o   <= nxt inside {FINAL, WAIT_CVF, WAIT_TAG};
      data_valid_o     <= nxt inside {AD, WAIT_AD, PT, WAIT_CV, WAIT_EC, FINAL, WAIT_CVF, WAIT_TAG};
      case (nxt)
        AD, WAIT_AD:                          data_o <= AD_WORD;
        PT, FINAL:                            data_o <= block_nxt;
        WAIT_CV, WAIT_EC, WAIT_CVF, WAIT_TAG: data_o <= data_o;
        default:                              data_o <= '0;
      endcase

      cipher_word_valid_o <= 1'b0;
      tag_valid_o         <= 1'b0;
      if ((state == WAIT_CV || state == WAIT_CVF) && cipher_valid_i) begin
        cipher_word_o       <= cipher_i;
        cipher_index_o      <= blk_cnt;
        cipher_word_valid_o <= 1'b1;
      end
      if (state == WAIT_TAG && end_tag_i) begin
        tag_o       <= tag_i;
        tag_valid_o <= 1'b1;
      end

      busy_o <= !(nxt == IDLE || nxt == DONE);
      done_o <= (nxt == DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_ecg_feeder.sv
`default_nettype none
// tb_ascon_ecg_feeder : random-stimulus bench with a behavioural ascon core and
// a byte-record reference model.  rev 1.0
module tb_ascon_ecg_feeder;

  localparam logic [63:0] KEY = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    [2];
  logic         start    [2];
  logic [7:0]   bbyte    [2];
  logic         bvalid   [2];
  logic         bready   [2];
  logic         init     [2];
  logic         ad       [2];
  logic         fin      [2];
  logic [63:0]  data     [2];
  logic         dv       [2];
  logic         end_init [2];
  logic         end_ad   [2];
  logic [63:0]  cipher   [2];
  logic         cv       [2];
  logic         end_c    [2];
  logic [127:0] tag_in   [2];
  logic         end_tag  [2];
  logic [63:0]  cw       [2];
  logic         cwv      [2];
  logic [7:0]   cidx     [2];
  logic [127:0] tag_out  [2];
  logic         tagv     [2];
  logic         busy     [2];
  logic         done     [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ascon_ecg_feeder #(.NB_BYTES(k == 0 ? 181 : 16)) u_dut (
      .clock_i              (clk),
      .resetb_i             (rst_n[k]),
      .start_i              (start[k]),
      .byte_i               (bbyte[k]),
      .byte_valid_i         (bvalid[k]),
      .byte_ready_o         (bready[k]),
      .init_o               (init[k]),
      .associate_data_o     (ad[k]),
      .finalisation_o       (fin[k]),
      .data_o               (data[k]),
      .data_valid_o         (dv[k]),
      .end_initialisation_i (end_init[k]),
      .end_associate_i      (end_ad[k]),
      .cipher_i             (cipher[k]),
      .cipher_valid_i       (cv[k]),
      .end_cipher_i         (end_c[k]),
      .tag_i                (tag_in[k]),
      .end_tag_i            (end_tag[k]),
      .cipher_word_o        (cw[k]),
      .cipher_word_valid_o  (cwv[k]),
      .cipher_index_o       (cidx[k]),
      .tag_o                (tag_out[k]),
      .tag_valid_o          (tagv[k]),
      .busy_o               (busy[k]),
      .done_o               (done[k])
    );
  end

  int           n_chk;
  int           n_fail;
  logic [7:0]   src[$];
  logic [63:0]  exp_blk[$];
  logic [127:0] exp_tag;
  int           sidx;
  int           gap;
  int           feed_on;
  int           npulse;
  int           ntag;

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One clock: observe output pulses and drive the byte source, all at negedge.
  task automatic tick(input int k);
    @(negedge clk);
    if (cwv[k]) begin
      check_val("cipher_index", 128'(cidx[k]), 128'(npulse));
      if (npulse < exp_blk.size())
        check_val("cipher_word", 128'(cw[k]), 128'(exp_blk[npulse] ^ KEY ^ 64'(npulse)));
      npulse++;
    end
    if (tagv[k]) begin
      check_val("tag", tag_out[k], exp_tag);
      ntag++;
    end
    if (feed_on != 0 && sidx < src.size() && (gap == 0 || $urandom_range(0, 9) < 3)) begin
      bvalid[k] = 1'b1;
      bbyte[k]  = src[sidx];
    end else begin
      bvalid[k] = 1'b0;
      bbyte[k]  = 8'($urandom);
    end
    if (bvalid[k] && bready[k]) sidx++;
  endtask

  function automatic bit seen(input int k, input int what);
    case (what)
      0:       return init[k];
      1:       return dv[k] && ad[k];
      default: return dv[k] && !ad[k];
    endcase
  endfunction

  task automatic wait_for(input int k, input int what, input string name, output bit ok);
    ok = seen(k, what);
    for (int n = 0; n < 3000 && !ok; n++) begin
      tick(k);
      ok = seen(k, what);
    end
    check_val(name, 128'(ok), 128'(1));
  endtask

  task automatic hold(input int k, input int n, input string name);
    logic [67:0] snap;
    snap = {init[k], ad[k], fin[k], dv[k], data[k]};
    for (int i = 0; i < n; i++) begin
      tick(k);
      check_val(name, 128'({init[k], ad[k], fin[k], dv[k], data[k]}), 128'(snap));
    end
  endtask

  task automatic build_record(input int nb, input bit fixed);
    logic [71:0] head;
    logic [39:0] tail;
    logic [63:0] w;
    int          nfull;
    int          r;
    head  = 72'h5A5B5B5A5A5A5A5A59;
    tail  = 40'h5857545252;
    nfull = nb / 8;
    r     = nb % 8;
    src.delete();
    exp_blk.delete();
    for (int i = 0; i < nb; i++) src.push_back(8'($urandom));
    if (fixed) begin
      for (int i = 0; i < 9; i++) src[i] = head[71 - 8*i -: 8];
      for (int i = 0; i < 5; i++) src[nb - 5 + i] = tail[39 - 8*i -: 8];
    end
    for (int b = 0; b < nfull; b++) begin
      w = '0;
      for (int i = 0; i < 8; i++) w = (w << 8) | 64'(src[8*b + i]);
      exp_blk.push_back(w);
    end
    w = '0;
    for (int i = 0; i < r; i++) w = (w << 8) | 64'(src[8*nfull + i]);
    w = (w << 8) | 64'h80;
    w = w << (8 * (7 - r));
    exp_blk.push_back(w);
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_record(input int k, input int nb, input int gap_m, input bit poke,
                            input int abort_at, input bit fixed);
    int nfull;
    bit ok;
    nfull   = nb / 8;
    sidx    = 0;
    npulse  = 0;
    ntag    = 0;
    gap     = gap_m;
    feed_on = 1;

    start[k] = 1'b1;
    tick(k);
    start[k] = 1'b0;
    check_val("busy_after_start", 128'(busy[k]), 128'(1));
    check_val("done_after_start", 128'(done[k]), 128'(0));

    wait_for(k, 0, "init_seen", ok);
    if (!ok) return;
    hold(k, 2, "init_hold");
    end_init[k] = 1'b1;
    tick(k);
    end_init[k] = 1'b0;

    wait_for(k, 1, "ad_seen", ok);
    if (!ok) return;
    check_val("ad_word", 128'(data[k]), 128'(64'h4120746F20428000));
    hold(k, 2, "ad_hold");
    end_ad[k] = 1'b1;
    tick(k);
    end_ad[k] = 1'b0;

    for (int b = 0; b <= nfull; b++) begin
      wait_for(k, 2, "pt_seen", ok);
      if (!ok) return;
      check_val("pt_data", 128'(data[k]), 128'(exp_blk[b]));
      check_val("pt_final_flag", 128'(fin[k]), 128'(b == nfull));
      check_val("pt_no_ready", 128'(bready[k]), 128'(0));
      if (b == nfull) check_val("all_bytes_taken", 128'(sidx), 128'(nb));
      if (fixed && b == 0) check_val("first_pt", 128'(data[k]), 128'(64'h5A5B5B5A5A5A5A5A));
      if (fixed && b == nfull) check_val("final_pt", 128'(data[k]), 128'(64'h5857545252800000));
      hold(k, 1, "pt_hold");
      start[k] = poke && (b == 1);
      tick(k);
      start[k] = 1'b0;
      hold(k, 1, "cv_wait_hold");

      cv[k]     = 1'b1;
      cipher[k] = exp_blk[b] ^ KEY ^ 64'(b);
      hold(k, 4, "cv_hold");
      cv[k]     = 1'b0;
      cipher[k] = '0;

      if (b == abort_at) begin
        tick(k);
        rst_n[k] = 1'b0;
        #1;
        check_val("reset_ctrl", 128'({bready[k], init[k], ad[k], fin[k], dv[k], cwv[k],
                                     tagv[k], busy[k], done[k], cidx[k]}), 128'(0));
        check_val("reset_words", {data[k], cw[k]}, 128'(0));
        check_val("reset_tag", tag_out[k], 128'(0));
        check_val("pulses_before_abort", 128'(npulse), 128'(b + 1));
        feed_on = 0;
        repeat (2) tick(k);
        rst_n[k] = 1'b1;
        repeat (5) tick(k);
        check_val("idle_ready", 128'(bready[k]), 128'(0));
        check_val("idle_busy", 128'({busy[k], done[k]}), 128'(0));
        check_val("no_pulse_after_reset", 128'({npulse[7:0], ntag[7:0]}), 128'({8'(b + 1), 8'd0}));
        return;
      end

      hold(k, 3, "ec_hold");
      if (b < nfull) begin
        end_c[k] = 1'b1;
        tick(k);
        end_c[k] = 1'b0;
      end else begin
        tag_in[k]  = exp_tag;
        end_tag[k] = 1'b1;
        tick(k);
        end_tag[k] = 1'b0;
        tag_in[k]  = '0;
      end
    end

    feed_on = 0;
    repeat (3) tick(k);
    check_val("pulse_count", 128'(npulse), 128'(nfull + 1));
    check_val("tag_count", 128'(ntag), 128'(1));
    check_val("done_level", 128'(done[k]), 128'(1));
    check_val("busy_in_done", 128'(busy[k]), 128'(0));
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    sidx    = 0;
    gap     = 0;
    feed_on = 0;
    npulse  = 0;
    ntag    = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k]    = 1'b0;
      start[k]    = 1'b0;
      bbyte[k]    = '0;
      bvalid[k]   = 1'b0;
      end_init[k] = 1'b0;
      end_ad[k]   = 1'b0;
      cipher[k]   = '0;
      cv[k]       = 1'b0;
      end_c[k]    = 1'b0;
      tag_in[k]   = '0;
      end_tag[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    tick(0);
    for (int k = 0; k < 2; k++) begin
      check_val("reset_state_ctrl", 128'({bready[k], init[k], ad[k], fin[k], dv[k],
                                         cwv[k], tagv[k], busy[k], done[k]}), 128'(0));
      check_val("reset_state_data", 128'(data[k]), 128'(0));
    end

    build_record(181, 1'b1);
    run_record(0, 181, 0, 1'b0, -1, 1'b1);
    run_record(0, 181, 1, 1'b1, -1, 1'b1);
    build_record(181, 1'b0);
    run_record(0, 181, 1, 1'b0, 5, 1'b0);
    build_record(181, 1'b0);
    run_record(0, 181, 0, 1'b0, -1, 1'b0);
    build_record(16, 1'b0);
    run_record(1, 16, 1, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
